// File: rtl/array_ops_pkg.sv
// Shared constants and types for the array routing blocks.
// Default array geometry, the flat vector width and the route-select encoding.
package array_ops_pkg;

    localparam int DEFAULT_BIT_WIDTH  = 4;
    localparam int DEFAULT_ROWS       = 8;
    localparam int DEFAULT_COLS       = 8;
    localparam int DEFAULT_FLAT_WIDTH = DEFAULT_ROWS * DEFAULT_COLS * DEFAULT_BIT_WIDTH;

    // Width of the optional per-port drain counters.
    localparam int COUNT_WIDTH = 32;

    // Index of each output slot; matches the value of the condition input.
    typedef enum logic {
        ROUTE_FALSE = 1'b0,
        ROUTE_TRUE  = 1'b1
    } route_e;

    // Flat vector width for an arbitrary array geometry.
    function automatic int flat_width(input int bit_width, input int rows, input int cols);
        return rows * cols * bit_width;
    endfunction

endpackage

// File: rtl/array_hold_slot.sv
// One-entry holding register for a flat array with a valid flag.
// A load always wins over a drain, so drain+load in one cycle keeps valid high.
module array_hold_slot #(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] data_in,
    output logic             valid,
    output logic [WIDTH-1:0] data_out
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next-state: load replaces contents; a drain without load empties the slot.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = data_in;
        end else if (valid_q && drain) begin
            valid_d = 1'b0;
        end
    end

    // Slot registers; reset empties the slot and zeroes the held data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid    = valid_q;
    assign data_out = data_q;

endmodule

// File: rtl/convert_1d_to_3d_array.sv
// Restores a [ROWS][COLS] array of BIT_WIDTH elements from a flat vector.
// Uses the same element placement as convert_3d_to_1d_array.
module convert_1d_to_3d_array #(
    parameter int BIT_WIDTH = 4,
    parameter int ROWS      = 8,
    parameter int COLS      = 8
) (
    input  logic [ROWS*COLS*BIT_WIDTH-1:0] in_flat,
    output logic [BIT_WIDTH-1:0]           out_array [ROWS-1:0][COLS-1:0]
);

    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
            for (genvar gj = 0; gj < COLS; gj++) begin : g_col
                assign out_array[gi][gj] = in_flat[(gi*COLS + gj)*BIT_WIDTH +: BIT_WIDTH];
            end
        end
    endgenerate

endmodule

// File: rtl/convert_3d_to_1d_array.sv
// Packs a [ROWS][COLS] array of BIT_WIDTH elements into one flat vector.
// Element [r][c] lands at bit offset (r*COLS + c)*BIT_WIDTH.
module convert_3d_to_1d_array #(
    parameter int BIT_WIDTH = 4,
    parameter int ROWS      = 8,
    parameter int COLS      = 8
) (
    input  logic [BIT_WIDTH-1:0]           in_array [ROWS-1:0][COLS-1:0],
    output logic [ROWS*COLS*BIT_WIDTH-1:0] out_flat
);

    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
            for (genvar gj = 0; gj < COLS; gj++) begin : g_col
                assign out_flat[(gi*COLS + gj)*BIT_WIDTH +: BIT_WIDTH] = in_array[gi][gj];
            end
        end
    endgenerate

endmodule

// File: rtl/demux_3d_array.sv
// Routes a 2-D array of elements to one of two registered outputs by condition.
// Each output owns a one-entry slot with valid/ready handshake.
// Optional feature: define DEMUX_3D_ARRAY_COUNT_EN to add 32-bit drain counters
// count_true / count_false.
module demux_3d_array
    import array_ops_pkg::*;
#(
    parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH,
    parameter int ROWS      = DEFAULT_ROWS,
    parameter int COLS      = DEFAULT_COLS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 condition,
    input  logic [BIT_WIDTH-1:0] in [ROWS-1:0][COLS-1:0],
    output logic                 out_true_valid,
    output logic                 out_false_valid,
    input  logic                 out_true_ready,
    input  logic                 out_false_ready,
    output logic [BIT_WIDTH-1:0] out_true [ROWS-1:0][COLS-1:0],
    output logic [BIT_WIDTH-1:0] out_false [ROWS-1:0][COLS-1:0]
`ifdef DEMUX_3D_ARRAY_COUNT_EN
    ,
    output logic [COUNT_WIDTH-1:0] count_true,
    output logic [COUNT_WIDTH-1:0] count_false
`endif
);

    localparam int FLAT_W = flat_width(BIT_WIDTH, ROWS, COLS);

    route_e              route;
    logic                in_hs;
    logic [1:0]          slot_load;
    logic [1:0]          slot_ready;
    logic [1:0]          slot_valid;
    logic [FLAT_W-1:0]   in_flat;
    logic [FLAT_W-1:0]   slot_data [2];

    assign route = route_e'(condition);

    // Accept when the selected slot is empty or is being drained this cycle.
    // Held low during reset so no handshake is signalled in a reset cycle.
    assign in_ready = !rst && (!slot_valid[route] || slot_ready[route]);
    assign in_hs    = in_valid && in_ready;

    assign slot_ready[ROUTE_TRUE]  = out_true_ready;
    assign slot_ready[ROUTE_FALSE] = out_false_ready;

    convert_3d_to_1d_array #(
        .BIT_WIDTH (BIT_WIDTH),
        .ROWS      (ROWS),
        .COLS      (COLS)
    ) u_flatten (
        .in_array (in),
        .out_flat (in_flat)
    );

    // One holding slot per route; only the slot matching condition is loaded.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            assign slot_load[gi] = in_hs && (route == route_e'(gi));

            array_hold_slot #(
                .WIDTH (FLAT_W)
            ) u_slot (
                .clk      (clk),
                .rst      (rst),
                .load     (slot_load[gi]),
                .drain    (slot_ready[gi]),
                .data_in  (in_flat),
                .valid    (slot_valid[gi]),
                .data_out (slot_data[gi])
            );
        end
    endgenerate

    assign out_true_valid  = slot_valid[ROUTE_TRUE];
    assign out_false_valid = slot_valid[ROUTE_FALSE];

    convert_1d_to_3d_array #(
        .BIT_WIDTH (BIT_WIDTH),
        .ROWS      (ROWS),
        .COLS      (COLS)
    ) u_restore_true (
        .in_flat   (slot_data[ROUTE_TRUE]),
        .out_array (out_true)
    );

    convert_1d_to_3d_array #(
        .BIT_WIDTH (BIT_WIDTH),
        .ROWS      (ROWS),
        .COLS      (COLS)
    ) u_restore_false (
        .in_flat   (slot_data[ROUTE_FALSE]),
        .out_array (out_false)
    );

`ifdef DEMUX_3D_ARRAY_COUNT_EN
    logic [COUNT_WIDTH-1:0] count_true_q;
    logic [COUNT_WIDTH-1:0] count_true_d;
    logic [COUNT_WIDTH-1:0] count_false_q;
    logic [COUNT_WIDTH-1:0] count_false_d;

    // Count completed output handshakes; natural wrap at the counter width.
    always_comb begin
        count_true_d  = count_true_q  + COUNT_WIDTH'(out_true_valid  && out_true_ready);
        count_false_d = count_false_q + COUNT_WIDTH'(out_false_valid && out_false_ready);
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_true_q  <= '0;
            count_false_q <= '0;
        end else begin
            count_true_q  <= count_true_d;
            count_false_q <= count_false_d;
        end
    end

    assign count_true  = count_true_q;
    assign count_false = count_false_q;
`endif

endmodule

// File: tb/tb_demux_3d_array.sv
// Self-checking bench for demux_3d_array: directed vector table, hand-written
// reset/idle sequences and a randomized run against a slot-level reference model.
module tb_demux_3d_array;

    localparam int BW = 4;
    localparam int R  = 8;
    localparam int C  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          condition;
    logic [BW-1:0] in_arr [R-1:0][C-1:0];
    logic          out_true_valid;
    logic          out_false_valid;
    logic          out_true_ready;
    logic          out_false_ready;
    logic [BW-1:0] out_true [R-1:0][C-1:0];
    logic [BW-1:0] out_false [R-1:0][C-1:0];
`ifdef DEMUX_3D_ARRAY_COUNT_EN
    logic [31:0]   count_true;
    logic [31:0]   count_false;
`endif

    always #5 clk = ~clk;

    demux_3d_array #(
        .BIT_WIDTH (BW),
        .ROWS      (R),
        .COLS      (C)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .condition       (condition),
        .in              (in_arr),
        .out_true_valid  (out_true_valid),
        .out_false_valid (out_false_valid),
        .out_true_ready  (out_true_ready),
        .out_false_ready (out_false_ready),
        .out_true        (out_true),
        .out_false       (out_false)
`ifdef DEMUX_3D_ARRAY_COUNT_EN
        ,
        .count_true      (count_true),
        .count_false     (count_false)
`endif
    );

    // Reference model: each output is a one-deep buffer holding a whole array.
    bit            m_t_full;
    bit            m_f_full;
    logic [BW-1:0] m_t [R-1:0][C-1:0];
    logic [BW-1:0] m_f [R-1:0][C-1:0];
    int unsigned   m_cnt_t;
    int unsigned   m_cnt_f;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit            iv;
        bit            cond;
        bit            tr;
        bit            fr;
        logic [BW-1:0] val;
        bit            exp_ready;
        bit            exp_tv;
        bit            exp_fv;
        logic [BW-1:0] exp_t;
        logic [BW-1:0] exp_f;
    } vec_t;

    vec_t vecs [8];

    task automatic model_reset();
        m_t_full = 0;
        m_f_full = 0;
        m_cnt_t  = 0;
        m_cnt_f  = 0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                m_t[r][c] = '0;
                m_f[r][c] = '0;
            end
    endtask

    function automatic bit model_ready();
        // A buffer can take a new array if it is empty or its consumer takes the old one now.
        if (condition) return !m_t_full || out_true_ready;
        return !m_f_full || out_false_ready;
    endfunction

    // Advance the model by one clock, using the inputs that were present at the edge.
    task automatic model_clock(input bit accept);
        if (m_t_full && out_true_ready) begin m_t_full = 0; m_cnt_t++; end
        if (m_f_full && out_false_ready) begin m_f_full = 0; m_cnt_f++; end
        if (accept) begin
            if (condition) begin m_t = in_arr; m_t_full = 1; end
            else           begin m_f = in_arr; m_f_full = 1; end
        end
    endtask

    task automatic fill_in(input logic [BW-1:0] val);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                in_arr[r][c] = val;
    endtask

    task automatic fill_rand();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                in_arr[r][c] = BW'($urandom_range(0, (1 << BW) - 1));
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Compare every element of one output against a single constant.
    task automatic check_fill(input string name, input bit is_true, input logic [BW-1:0] val);
        logic [BW-1:0] e;
        logic [BW-1:0] got;
        bit            ok;
        ok  = 1;
        got = '0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                e = is_true ? out_true[r][c] : out_false[r][c];
                if (ok && (e !== val)) begin ok = 0; got = e; end
            end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: element got %h expected %h", name, got, val);
        end
    endtask

    // Compare both outputs, element by element, against the model buffers.
    task automatic check_model(input string tag);
        bit ok_t;
        bit ok_f;
        int br;
        int bc;
        ok_t = 1;
        ok_f = 1;
        br = 0;
        bc = 0;
        check_bit({tag, " out_true_valid"}, out_true_valid, m_t_full);
        check_bit({tag, " out_false_valid"}, out_false_valid, m_f_full);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                if (ok_t && out_true[r][c] !== m_t[r][c]) begin ok_t = 0; br = r; bc = c; end
                if (ok_f && out_false[r][c] !== m_f[r][c]) begin ok_f = 0; br = r; bc = c; end
            end
        n_cmp += 2;
        if (!ok_t) begin
            n_bad++;
            $display("FAIL %s out_true[%0d][%0d]: got %h expected %h", tag, br, bc,
                     out_true[br][bc], m_t[br][bc]);
        end
        if (!ok_f) begin
            n_bad++;
            $display("FAIL %s out_false[%0d][%0d]: got %h expected %h", tag, br, bc,
                     out_false[br][bc], m_f[br][bc]);
        end
`ifdef DEMUX_3D_ARRAY_COUNT_EN
        check_word({tag, " count_true"}, count_true, m_cnt_t);
        check_word({tag, " count_false"}, count_false, m_cnt_f);
`endif
    endtask

    // One clock with the current inputs: check in_ready before the edge, outputs after.
    task automatic cycle_model(input string tag);
        bit acc;
        #1;
        acc = in_valid && model_ready();
        check_bit({tag, " in_ready"}, in_ready, model_ready());
        @(posedge clk);
        model_clock(acc);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        // Directed vectors from an empty state; expected values worked out by hand.
        //           iv cond tr fr val    rdy tv fv  t     f
        vecs[0] = '{1, 1, 0, 0, 4'h5,  1, 1, 0, 4'h5, 4'h0};
        vecs[1] = '{1, 1, 0, 0, 4'h7,  0, 1, 0, 4'h5, 4'h0};
        vecs[2] = '{1, 0, 0, 0, 4'hA,  1, 1, 1, 4'h5, 4'hA};
        vecs[3] = '{0, 1, 1, 0, 4'h0,  1, 0, 1, 4'h5, 4'hA};
        vecs[4] = '{1, 1, 1, 1, 4'h1,  1, 1, 0, 4'h1, 4'hA};
        vecs[5] = '{1, 1, 1, 0, 4'h2,  1, 1, 0, 4'h2, 4'hA};
        vecs[6] = '{1, 1, 1, 0, 4'h3,  1, 1, 0, 4'h3, 4'hA};
        vecs[7] = '{0, 0, 1, 0, 4'h0,  1, 0, 0, 4'h3, 4'hA};

        rst             = 1'b1;
        in_valid        = 1'b0;
        condition       = 1'b0;
        out_true_ready  = 1'b0;
        out_false_ready = 1'b0;
        fill_in(4'hF);
        model_reset();

        // Reset state.
        @(posedge clk);
        @(posedge clk);
        #1;
        check_bit("reset out_true_valid", out_true_valid, 1'b0);
        check_bit("reset out_false_valid", out_false_valid, 1'b0);
        check_fill("reset out_true", 1, 4'h0);
        check_fill("reset out_false", 0, 4'h0);
        rst = 1'b0;

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            bit acc;
            string tag;
            tag = $sformatf("vec%0d", i);
            in_valid        = vecs[i].iv;
            condition       = vecs[i].cond;
            out_true_ready  = vecs[i].tr;
            out_false_ready = vecs[i].fr;
            fill_in(vecs[i].val);
            #1;
            acc = in_valid && model_ready();
            check_bit({tag, " in_ready"}, in_ready, vecs[i].exp_ready);
            @(posedge clk);
            model_clock(acc);
            #1;
            check_bit({tag, " out_true_valid"}, out_true_valid, vecs[i].exp_tv);
            check_bit({tag, " out_false_valid"}, out_false_valid, vecs[i].exp_fv);
            check_fill({tag, " out_true"}, 1, vecs[i].exp_t);
            check_fill({tag, " out_false"}, 0, vecs[i].exp_f);
            $display("vec%0d iv=%0b cond=%0b tr=%0b fr=%0b val=%h", i,
                     vecs[i].iv, vecs[i].cond, vecs[i].tr, vecs[i].fr, vecs[i].val);
        end

        // Condition toggling without in_valid must not disturb anything.
        in_valid        = 1'b0;
        out_true_ready  = 1'b0;
        out_false_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            condition = i[0];
            fill_in(4'h9);
            @(posedge clk);
            #1;
            check_bit($sformatf("idle%0d out_true_valid", i), out_true_valid, 1'b0);
            check_bit($sformatf("idle%0d out_false_valid", i), out_false_valid, 1'b0);
            check_fill($sformatf("idle%0d out_true", i), 1, 4'h3);
            check_fill($sformatf("idle%0d out_false", i), 0, 4'hA);
            $display("idle%0d cond=%0b", i, condition);
        end

        // Fill both slots, then assert reset between edges.
        in_valid  = 1'b1;
        condition = 1'b1;
        fill_in(4'h9);
        @(posedge clk);
        #1;
        condition = 1'b0;
        fill_in(4'h6);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_bit("prerst out_true_valid", out_true_valid, 1'b1);
        check_bit("prerst out_false_valid", out_false_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_bit("asyncrst out_true_valid", out_true_valid, 1'b0);
        check_bit("asyncrst out_false_valid", out_false_valid, 1'b0);
        check_fill("asyncrst out_true", 1, 4'h0);
        check_fill("asyncrst out_false", 0, 4'h0);
        $display("async reset applied with both slots full");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        in_valid  = 1'b1;
        condition = 1'b1;
        #1;
        check_bit("postrst in_ready", in_ready, 1'b1);
        in_valid = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            in_valid        = ($urandom_range(0, 3) != 0);
            condition       = $urandom_range(0, 1) != 0;
            out_true_ready  = ($urandom_range(0, 2) != 0);
            out_false_ready = ($urandom_range(0, 2) != 0);
            fill_rand();
            cycle_model($sformatf("rnd%0d", i));
            $display("rnd%0d iv=%0b cond=%0b tr=%0b fr=%0b tv=%0b fv=%0b", i, in_valid,
                     condition, out_true_ready, out_false_ready, out_true_valid, out_false_valid);
        end

`ifdef DEMUX_3D_ARRAY_COUNT_EN
        // Counter test: 3 true and 2 false drains from reset, then wrap.
        in_valid = 1'b0;
        do_reset();
        out_true_ready  = 1'b1;
        out_false_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid  = (i < 5);
            condition = (i % 2 == 0);
            fill_in(BW'(i));
            cycle_model($sformatf("cnt%0d", i));
            $display("cnt%0d count_true=%0d count_false=%0d", i, count_true, count_false);
        end
        check_word("cnt count_true", count_true, 32'd3);
        check_word("cnt count_false", count_false, 32'd2);
        dut.count_true_q = 32'hFFFF_FFFF;
        m_cnt_t = 32'hFFFF_FFFF;
        in_valid  = 1'b1;
        condition = 1'b1;
        cycle_model("wrap_fill");
        in_valid = 1'b0;
        cycle_model("wrap_drain");
        check_word("wrap count_true", count_true, 32'd0);
        $display("wrap count_true=%0d", count_true);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
